cci_mpf_req_arbiter: RTL

- Parametrised N-client request arbiter and response router; lets several test engines share one MPF/FIU request channel.
- Sits between N test engine instances and the AFU-side MPF port.
- Tags each granted request with the client index in the top bits of its mdata field. Routes each response back to the client by that tag.
- Enforces a per-client outstanding-request limit; round-robin fairness.

---
 rtl/cci_mpf_req_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cci_mpf_req_arbiter.sv
// N-client round-robin request arbiter and tag-based response router with per-client
// outstanding limits. Define CCI_MPF_REQ_ARB_STATS_EN to add grant / almost-full statistics.
module cci_mpf_req_arbiter #(
    parameter int N_CLIENTS       = 4,
    parameter int HDR_W           = 80,
    parameter int MDATA_LSB       = 0,
    parameter int MDATA_W         = 16,
    parameter int MAX_OUTSTANDING = 64,
    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CLIENTS-1:0]       c_req_valid,
    input  logic [N_CLIENTS*HDR_W-1:0] c_req_hdr,
    output logic [N_CLIENTS-1:0]       c_req_ready,
    output logic [N_CLIENTS-1:0]       c_rsp_valid,
    output logic [HDR_W-1:0]           c_rsp_hdr,
    output logic                       f_req_valid,
    output logic [HDR_W-1:0]           f_req_hdr,
    input  logic                       f_almost_full,
    input  logic                       f_rsp_valid,
    input  logic [HDR_W-1:0]           f_rsp_hdr,
    output logic                       err_bad_tag,
    output logic [N_CLIENTS*16-1:0]    outstanding
`ifdef CCI_MPF_REQ_ARB_STATS_EN
   ,output logic [N_CLIENTS*32-1:0]    stat_grants,
    output logic [31:0]                stat_afull_cycles
`endif
);

    localparam int          TAG_LSB = MDATA_LSB + MDATA_W - IDX_W;
    localparam logic [15:0] MAX_CNT = 16'(MAX_OUTSTANDING);

    logic [N_CLIENTS-1:0][HDR_W-1:0] w_req_hdrs;
    logic [N_CLIENTS-1:0][15:0]      r_cnt;
    logic [N_CLIENTS-1:0]            w_elig, w_inc, w_dec, r_rsp_valid;
    logic [IDX_W-1:0]                r_rr_ptr, w_win, w_win_hi, w_win_lo, w_tag;
    logic                            w_found_hi, w_found_lo, w_grant, w_tag_ok, w_rsp_route;
    logic                            w_underflow, r_req_valid, r_err;
    logic [HDR_W-1:0]                w_req_tagged, w_rsp_clr, r_req_hdr, r_rsp_hdr;

    assign w_req_hdrs = c_req_hdr;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_CLIENTS; i++)
            w_elig[i] = c_req_valid[i] && (r_cnt[i] < MAX_CNT);
    end

    // Lowest eligible index at/above the pointer wins; otherwise lowest below it (wrap).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                if (i >= int'(r_rr_ptr)) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = IDX_W'(i);
                end else begin
                    w_found_lo = 1'b1;
                    w_win_lo   = IDX_W'(i);
                end
            end
        end
    end

    assign w_win   = w_found_hi ? w_win_hi : w_win_lo;
    assign w_grant = !reset && !f_almost_full && (w_found_hi || w_found_lo);

    always_comb begin
        c_req_ready = '0;
        if (w_grant) c_req_ready[w_win] = 1'b1;
    end

    always_comb begin
        w_req_tagged = w_req_hdrs[w_win];
        w_req_tagged[TAG_LSB +: IDX_W] = w_win;
    end

    assign w_tag       = f_rsp_hdr[TAG_LSB +: IDX_W];
    assign w_tag_ok    = int'(w_tag) < N_CLIENTS;
    assign w_rsp_route = f_rsp_valid && w_tag_ok;

    always_comb begin
        w_rsp_clr = f_rsp_hdr;
        w_rsp_clr[TAG_LSB +: IDX_W] = '0;
    end

    // A grant and a routed response to the same client cancel; an unmatched decrement at 0 is an error.
    always_comb begin
        w_inc       = '0;
        w_dec       = '0;
        w_underflow = 1'b0;
        if (w_grant)     w_inc[w_win] = 1'b1;
        if (w_rsp_route) w_dec[w_tag] = 1'b1;
        for (int i = 0; i < N_CLIENTS; i++)
            if (w_dec[i] && !w_inc[i] && r_cnt[i] == 16'd0) w_underflow = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_hdr   <= '0;
            r_rsp_valid <= '0;
            r_rsp_hdr   <= '0;
            r_rr_ptr    <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_req_valid <= w_grant;
            if (w_grant) begin
                r_req_hdr <= w_req_tagged;
                r_rr_ptr  <= (int'(w_win) == N_CLIENTS - 1) ? '0 : w_win + 1'b1;
            end
            r_rsp_valid <= w_dec;
            if (w_rsp_route) r_rsp_hdr <= w_rsp_clr;
            if ((f_rsp_valid && !w_tag_ok) || w_underflow) r_err <= 1'b1;
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                else if (w_dec[i] && !w_inc[i] && r_cnt[i] != 16'd0)
                    r_cnt[i] <= r_cnt[i] - 16'd1;
            end
        end
    end

    assign f_req_valid = r_req_valid;
    assign f_req_hdr   = r_req_hdr;
    assign c_rsp_valid = r_rsp_valid;
    assign c_rsp_hdr   = r_rsp_hdr;
    assign err_bad_tag = r_err;
    assign outstanding = r_cnt;

`ifdef CCI_MPF_REQ_ARB_STATS_EN
    logic [N_CLIENTS-1:0][31:0] r_stat_grants;
    logic [31:0]                r_stat_afull;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_grants <= '0;
            r_stat_afull  <= '0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++)
                if (w_inc[i]) r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
            if (f_almost_full && |c_req_valid) r_stat_afull <= r_stat_afull + 32'd1;
        end
    end

    assign stat_grants       = r_stat_grants;
    assign stat_afull_cycles = r_stat_afull;
`endif

endmodule
